// File: rtl/instr_encoder_if.sv
// Host-side request port and imem write port of the instruction encoder.
// The encoder takes the slave view; the loader/host takes the master view.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [3:0]        in_cond;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_imm_sel;
  logic              in_load;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [3:0]        in_rm;
  logic [23:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output start, in_valid, in_kind, in_cond, in_cmd, in_s, in_imm_sel,
           in_load, in_rn, in_rd, in_rm, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  start, in_valid, in_kind, in_cond, in_cmd, in_s, in_imm_sel,
           in_load, in_rn, in_rd, in_rm, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: turns field-level requests into 32-bit ARM words (DP, LDR/STR, B)
// and writes them to consecutive imem words, one word every two cycles.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int BASE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  instr_encoder_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              legal_s;
  logic [31:0]       word_s;

  function automatic logic is_legal(input logic [1:0] kind, input logic [3:0] cmd,
                                    input logic imm_sel, input logic [23:0] imm);
    logic ok;
    case (kind)
      2'b00: ok = (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010}) &&
                  !(imm_sel && (imm[23:8] != 16'h0000));
      2'b01: ok = (imm[23:12] == 12'h000);
      2'b10: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // CMP only updates flags, so S is forced on and Rd is forced to zero.
  function automatic logic [31:0] encode(input logic [1:0] kind, input logic [3:0] cond,
                                         input logic [3:0] cmd, input logic s,
                                         input logic imm_sel, input logic load,
                                         input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [3:0] rm, input logic [23:0] imm);
    logic        s_eff;
    logic [3:0]  rd_eff;
    logic [31:0] w;
    s_eff  = (cmd == 4'b1010) ? 1'b1 : s;
    rd_eff = (cmd == 4'b1010) ? 4'h0 : rd;
    case (kind)
      2'b00: w = imm_sel ? {cond, 2'b00, 1'b1, cmd, s_eff, rn, rd_eff, 4'h0, imm[7:0]}
                         : {cond, 2'b00, 1'b0, cmd, s_eff, rn, rd_eff, 8'h00, rm};
      2'b01: w = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, imm[11:0]};
      2'b10: w = {cond, 2'b10, 1'b1, 1'b0, imm};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign legal_s = is_legal(bus.in_kind, bus.in_cmd, bus.in_imm_sel, bus.in_imm);
  assign word_s  = encode(bus.in_kind, bus.in_cond, bus.in_cmd, bus.in_s, bus.in_imm_sel,
                          bus.in_load, bus.in_rn, bus.in_rd, bus.in_rm, bus.in_imm);

  // Next-state and datapath update; start overrides everything, cancelling a pending write.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    if (bus.start) begin
      state_d    = ST_READY;
      mem_addr_d = ADDR_W'(BASE);
      count_d    = '0;
      full_d     = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_READY: begin
          if (bus.in_valid && legal_s) begin
            state_d     = ST_WRITE;
            mem_wdata_d = word_s;
          end else if (bus.in_valid) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_WRITE: begin
          count_d = count_q + (ADDR_W+1)'(1);
          // The address saturates on the last word instead of wrapping.
          if (count_d == (ADDR_W+1)'(DEPTH)) begin
            state_d = ST_FULL;
            full_d  = 1'b1;
          end else begin
            state_d    = ST_READY;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= ADDR_W'(BASE);
      mem_wdata_q <= 32'h0000_0000;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  // start/reset in the same cycle suppress the strobe so a cancelled write never reaches imem.
  assign bus.in_ready  = (state_q == ST_READY) && !bus.start && !reset;
  assign bus.mem_we    = (state_q == ST_WRITE) && !bus.start && !reset;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.err       = err_q;

endmodule
